snake_move_ctrl: RTL and testbench

Sequencer that owns the write/read port 0 of the 14x14 board memory (2-bit cells, 196 entries) and executes every board mutation of the snake game: board clear, initial snake placement, one-step moves with collision and food detection, and food placement. Port 1 of the board memory stays with the VGA renderer. Snake body addresses are held in an internal ring buffer so the tail can be erased without scanning the board.

---
 rtl/snake_move_ctrl_pkg.sv | 49 ++++
 rtl/snake_move_ctrl_if.sv | 12 +
 rtl/snake_move_ctrl_body_fifo.sv | 47 ++++
 rtl/snake_move_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/snake_move_ctrl_pkg.sv
// Shared definitions for the snake board sequencer: grid geometry, cell codes,
// directions and FSM state encoding.
package snake_move_ctrl_pkg;

    localparam int GRID_W     = 14;
    localparam int GRID_H     = 14;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 2;
    localparam int NUM_CELLS  = GRID_W * GRID_H;
    localparam int INIT_LEN   = 3;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [3:0]            coord_t;

    typedef enum logic [DATA_WIDTH-1:0] {
        CELL_EMPTY = 2'd0,
        CELL_BODY  = 2'd1,
        CELL_FOOD  = 2'd2,
        CELL_RSVD  = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CLEAR, ST_INIT, ST_FOOD_RD, ST_FOOD_CHK,
        ST_READY, ST_MOVE_RD, ST_MOVE_CHK, ST_TAIL, ST_DEAD
    } state_t;

    localparam addr_t  LAST_CELL = addr_t'(NUM_CELLS - 1);
    localparam addr_t  ROW_STEP  = addr_t'(GRID_W);
    localparam coord_t LAST_ROW  = coord_t'(GRID_H - 1);
    localparam coord_t LAST_COL  = coord_t'(GRID_W - 1);

    // Initial snake occupies row 7, cols 5..7, tail first.
    localparam addr_t  INIT_TAIL = addr_t'(103);
    localparam addr_t  INIT_HEAD = addr_t'(105);
    localparam coord_t INIT_ROW  = 4'd7;
    localparam coord_t INIT_COL  = 4'd7;

    function automatic addr_t cell_inc(input addr_t a);
        return (a == LAST_CELL) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/snake_move_ctrl_if.sv
// Board memory port 0: the sequencer is master, the board RAM is slave.
interface snake_move_ctrl_if;
    import snake_move_ctrl_pkg::*;

    addr_t                 o_mem_addr;
    logic [DATA_WIDTH-1:0] o_mem_wdata;
    logic                  o_mem_we;
    logic [DATA_WIDTH-1:0] i_mem_rdata;

    modport master (output o_mem_addr, o_mem_wdata, o_mem_we, input i_mem_rdata);
    modport slave  (input o_mem_addr, o_mem_wdata, o_mem_we, output i_mem_rdata);
endinterface

// File: rtl/snake_move_ctrl_body_fifo.sv
// Ring buffer of snake body cell addresses; the oldest entry is the tail.
module snake_body_fifo
    import snake_move_ctrl_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_clr,
    input  logic  i_push,
    input  logic  i_pop,
    input  addr_t i_din,
    output addr_t o_dout,
    output addr_t o_count
);

    addr_t r_buf [NUM_CELLS];
    addr_t r_wr_ptr;
    addr_t r_rd_ptr;
    addr_t r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= cell_inc(r_wr_ptr);
            if (i_pop)  r_rd_ptr <= cell_inc(r_rd_ptr);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_buf[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_buf[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/snake_move_ctrl.sv
// Owns board port 0: clears the board, places the snake and food, and executes
// one-step moves with collision and food detection.
module snake_move_ctrl
    import snake_move_ctrl_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_tick,
    input  logic [1:0]         i_dir,
    input  addr_t              i_food_addr,
    snake_move_ctrl_if.master  mem_if,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_ate,
    output logic               o_dead,
    output addr_t              o_len,
    output addr_t              o_head_addr
);

    state_t r_state;
    dir_t   r_dir;
    addr_t  r_cnt, r_probe, r_head, r_next_addr, r_len;
    coord_t r_row, r_col, r_next_row, r_next_col;

    dir_t   w_dir;
    addr_t  w_next_addr, w_seed, w_fifo_din, w_fifo_dout, w_fifo_count;
    coord_t w_next_row, w_next_col;
    logic   w_off_grid, w_full, w_idle, w_blocked, w_food;

    assign w_idle    = (r_state == ST_IDLE) || (r_state == ST_READY) || (r_state == ST_DEAD);
    assign w_dir     = ((i_dir ^ r_dir) == 2'd2) ? r_dir : dir_t'(i_dir);
    assign w_seed    = (i_food_addr > LAST_CELL) ? '0 : i_food_addr;
    assign w_full    = (w_fifo_count == addr_t'(NUM_CELLS));
    assign w_blocked = (mem_if.i_mem_rdata == CELL_BODY) || (mem_if.i_mem_rdata == CELL_RSVD);
    assign w_food    = (mem_if.i_mem_rdata == CELL_FOOD);
    assign w_fifo_din = (r_state == ST_INIT) ? (INIT_TAIL + r_cnt) : r_next_addr;

    snake_body_fifo u_body (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_idle && i_start),
        .i_push  ((r_state == ST_INIT) || ((r_state == ST_MOVE_CHK) && !w_blocked)),
        .i_pop   (r_state == ST_TAIL),
        .i_din   (w_fifo_din),
        .o_dout  (w_fifo_dout),
        .o_count (w_fifo_count)
    );

    // Row/col are tracked alongside the head so edge detection needs no divide.
    always_comb begin
        w_next_row  = r_row;
        w_next_col  = r_col;
        w_next_addr = r_head;
        w_off_grid  = 1'b0;
        case (w_dir)
            DIR_UP:    if (r_row == '0) w_off_grid = 1'b1;
                       else begin w_next_row = r_row - 1'b1; w_next_addr = r_head - ROW_STEP; end
            DIR_DOWN:  if (r_row == LAST_ROW) w_off_grid = 1'b1;
                       else begin w_next_row = r_row + 1'b1; w_next_addr = r_head + ROW_STEP; end
            DIR_RIGHT: if (r_col == LAST_COL) w_off_grid = 1'b1;
                       else begin w_next_col = r_col + 1'b1; w_next_addr = r_head + 1'b1; end
            DIR_LEFT:  if (r_col == '0) w_off_grid = 1'b1;
                       else begin w_next_col = r_col - 1'b1; w_next_addr = r_head - 1'b1; end
            default: ;
        endcase
    end

    // Port 0 is decoded from state because the head write depends on the read
    // data returned in the same MOVE_CHK / FOOD_CHK cycle.
    always_comb begin
        mem_if.o_mem_addr  = '0;
        mem_if.o_mem_wdata = CELL_EMPTY;
        mem_if.o_mem_we    = 1'b0;
        o_done             = 1'b0;
        o_ate              = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                mem_if.o_mem_addr = r_cnt;
                mem_if.o_mem_we   = 1'b1;
            end
            ST_INIT: begin
                mem_if.o_mem_addr  = w_fifo_din;
                mem_if.o_mem_wdata = CELL_BODY;
                mem_if.o_mem_we    = 1'b1;
            end
            ST_FOOD_RD: begin
                mem_if.o_mem_addr = r_probe;
                o_done            = w_full;
            end
            ST_FOOD_CHK: begin
                mem_if.o_mem_addr  = r_probe;
                mem_if.o_mem_wdata = CELL_FOOD;
                mem_if.o_mem_we    = (mem_if.i_mem_rdata == CELL_EMPTY);
                o_done             = (mem_if.i_mem_rdata == CELL_EMPTY);
            end
            ST_MOVE_RD: mem_if.o_mem_addr = r_next_addr;
            ST_MOVE_CHK: begin
                mem_if.o_mem_addr  = r_next_addr;
                mem_if.o_mem_wdata = CELL_BODY;
                mem_if.o_mem_we    = !w_blocked;
                o_ate              = w_food;
            end
            ST_TAIL: begin
                mem_if.o_mem_addr = w_fifo_dout;
                mem_if.o_mem_we   = 1'b1;
                o_done            = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_dir       <= DIR_RIGHT;
            r_cnt       <= '0;
            r_probe     <= '0;
            r_head      <= '0;
            r_next_addr <= '0;
            r_len       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_next_row  <= '0;
            r_next_col  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_READY, ST_DEAD: begin
                    if (i_start) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_len   <= '0;
                    end else if ((r_state == ST_READY) && i_tick) begin
                        r_dir <= w_dir;
                        if (w_off_grid) begin
                            r_state <= ST_DEAD;
                        end else begin
                            r_state     <= ST_MOVE_RD;
                            r_next_addr <= w_next_addr;
                            r_next_row  <= w_next_row;
                            r_next_col  <= w_next_col;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (r_cnt == LAST_CELL) begin
                        r_cnt   <= '0;
                        r_state <= ST_INIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_INIT: begin
                    if (r_cnt == addr_t'(INIT_LEN - 1)) begin
                        r_state <= ST_FOOD_RD;
                        r_head  <= INIT_HEAD;
                        r_row   <= INIT_ROW;
                        r_col   <= INIT_COL;
                        r_dir   <= DIR_RIGHT;
                        r_len   <= addr_t'(INIT_LEN);
                        r_probe <= w_seed;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FOOD_RD: r_state <= w_full ? ST_READY : ST_FOOD_CHK;
                ST_FOOD_CHK: begin
                    if (mem_if.i_mem_rdata == CELL_EMPTY) begin
                        r_state <= ST_READY;
                    end else begin
                        r_probe <= cell_inc(r_probe);
                        r_state <= ST_FOOD_RD;
                    end
                end
                ST_MOVE_RD: r_state <= ST_MOVE_CHK;
                ST_MOVE_CHK: begin
                    if (w_blocked) begin
                        r_state <= ST_DEAD;
                    end else begin
                        r_head <= r_next_addr;
                        r_row  <= r_next_row;
                        r_col  <= r_next_col;
                        if (w_food) begin
                            r_len   <= r_len + 1'b1;
                            r_probe <= w_seed;
                            r_state <= ST_FOOD_RD;
                        end else begin
                            r_state <= ST_TAIL;
                        end
                    end
                end
                ST_TAIL: r_state <= ST_READY;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy      = !w_idle;
    assign o_dead      = (r_state == ST_DEAD);
    assign o_len       = r_len;
    assign o_head_addr = r_head;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Scoreboard bench: expected board writes are queued by the stimulus and
// popped by a monitor on every write cycle of port 0.
module tb_snake_move_ctrl;
    import snake_move_ctrl_pkg::*;

    typedef struct packed {
        addr_t      addr;
        logic [1:0] data;
        logic       done;
        logic       ate;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, start, tick;
    logic [1:0] dir;
    addr_t      food_addr;
    logic       busy, done, ate, dead;
    addr_t      len, head;

    logic [1:0] board [NUM_CELLS];
    logic       poke_en;
    addr_t      poke_addr;
    logic [1:0] poke_data;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b1;

    // Hand-computed walk: right, reversed-left (kept right), 7x up, 4x right.
    int mv_dir  [13] = '{1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    int mv_head [13] = '{106, 107, 93, 79, 65, 51, 37, 23, 9, 10, 11, 12, 13};
    int mv_tail [13] = '{103, 104, 105, 106, 107, 93, 79, 65, 51, 37, 23, 9, 10};

    snake_move_ctrl_if mif ();

    snake_move_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_tick      (tick),
        .i_dir       (dir),
        .i_food_addr (food_addr),
        .mem_if      (mif),
        .o_busy      (busy),
        .o_done      (done),
        .o_ate       (ate),
        .o_dead      (dead),
        .o_len       (len),
        .o_head_addr (head)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mif.o_mem_we) board[mif.o_mem_addr] <= mif.o_mem_wdata;
        if (poke_en)      board[poke_addr]      <= poke_data;
        mif.i_mem_rdata <= board[mif.o_mem_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (mif.o_mem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%0d data=%0d expected=none",
                             mif.o_mem_addr, mif.o_mem_wdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", int'(mif.o_mem_addr), int'(mon_e.addr));
                    chk("wr_data", int'(mif.o_mem_wdata), int'(mon_e.data));
                    chk("wr_done", int'(done), int'(mon_e.done));
                    chk("wr_ate",  int'(ate),  int'(mon_e.ate));
                end
            end else if (done || ate) begin
                checks++;
                failures++;
                $display("FAIL stray_pulse done=%0d ate=%0d expected=0", done, ate);
            end
        end
    end

    task automatic push(input addr_t a, input logic [1:0] d, input logic dn, input logic at);
        exp_q.push_back('{a, d, dn, at});
    endtask

    task automatic poke(input addr_t a, input logic [1:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    // n counts cycles after the request cycle; the first call is already at n=1.
    task automatic wait_done(output int n, input int limit);
        n = 1;
        while (!done && n < limit) begin
            @(negedge clk);
            tick  = 1'b0;
            start = 1'b0;
            n++;
        end
        chk("done_seen", int'(done), 1);
    endtask

    task automatic do_start(input addr_t seed, input addr_t food_at);
        int n;
        for (int i = 0; i < NUM_CELLS; i++) push(addr_t'(i), CELL_EMPTY, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push(addr_t'(103 + i), CELL_BODY, 1'b0, 1'b0);
        push(food_at, CELL_FOOD, 1'b1, 1'b0);
        food_addr = seed;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        wait_done(n, 400);
        chk("start_latency", n, 201);
        @(negedge clk);
        chk("start_len", int'(len), 3);
        chk("start_head", int'(head), 105);
        chk("start_dead", int'(dead), 0);
        chk("start_idle", int'(busy), 0);
    endtask

    task automatic do_move(input int d, input int h, input int t, input logic busy_tick);
        int n;
        push(addr_t'(h), CELL_BODY, 1'b0, 1'b0);
        push(addr_t'(t), CELL_EMPTY, 1'b1, 1'b0);
        dir  = d[1:0];
        tick = 1'b1;
        @(negedge clk);
        tick = busy_tick;
        wait_done(n, 10);
        chk("move_latency", n, 3);
        @(negedge clk);
        chk("move_head", int'(head), h);
        chk("move_len", int'(len), 3);
        chk("move_idle", int'(busy), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; tick = 1'b0; dir = 2'd1; food_addr = '0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dead", int'(dead), 0);
        chk("rst_len", int'(len), 0);
        chk("rst_head", int'(head), 0);
        chk("rst_we", int'(mif.o_mem_we), 0);

        rst_n = 1'b1;
        tick  = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_tick_ignored", int'(busy), 0);

        do_start(addr_t'(20), addr_t'(20));
        for (int i = 0; i < 13; i++) do_move(mv_dir[i], mv_head[i], mv_tail[i], i == 1);

        // Head at row 0 col 13 heading right leaves the grid.
        dir  = 2'd1;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("dead_level", int'(dead), 1);
        chk("dead_busy", int'(busy), 0);
        chk("dead_head", int'(head), 13);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("dead_hold", int'(dead), 1);

        // Out-of-range seed probes from cell 0.
        do_start(addr_t'(200), addr_t'(0));

        // Eat pre-placed food at 106; seed 105 probes 105, 106, then hits 107.
        poke(addr_t'(106), CELL_FOOD);
        push(addr_t'(106), CELL_BODY, 1'b0, 1'b1);
        push(addr_t'(107), CELL_FOOD, 1'b1, 1'b0);
        food_addr = addr_t'(105);
        dir  = 2'd1;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        wait_done(n, 20);
        chk("eat_latency", n, 8);
        @(negedge clk);
        chk("eat_len", int'(len), 4);
        chk("eat_head", int'(head), 106);
        chk("queue_drained", exp_q.size(), 0);

        // Reset in the middle of CLEAR aborts to IDLE.
        mon_en = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("clear_busy", int'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_we", int'(mif.o_mem_we), 0);
        chk("abort_addr", int'(mif.o_mem_addr), 0);
        chk("abort_len", int'(len), 0);
        chk("abort_head", int'(head), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", int'(busy), 0);
        chk("abort_no_write", int'(mif.o_mem_we), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
